univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_bit_counter.sv | 30 +++
 rtl/univ_shift_reg.sv | 89 ++++++++
 tb/tb_univ_shift_reg.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register:
// manual mode codes and the auto-serialize FSM states.
package shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Down-counter tracking remaining auto-shifts of a frame;
// flags the final bit and saturates at zero.
module shift_bit_counter
    import shift_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_last
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with manual hold/shift/load modes
// and a start-triggered auto-serialize of a parallel word.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_done;

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_auto;
    logic             w_load;
    logic             w_dec;
    logic             w_last;

    assign w_shl  = {r_q[WIDTH-2:0], sin};
    assign w_shr  = {sin, r_q[WIDTH-1:1]};
    assign w_auto = MSB_FIRST ? w_shl : w_shr;
    assign w_load = (r_state == ST_IDLE) && start;
    assign w_dec  = (r_state == ST_SHIFT);

    shift_bit_counter #(
        .CW(CW)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (CW'(WIDTH)),
        .i_dec      (w_dec),
        .o_last     (w_last)
    );

    // start outranks mode; mode/start are ignored mid-frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_q     <= d;
                        r_state <= ST_SHIFT;
                    end else begin
                        case (mode)
                            MODE_SHL:  r_q <= w_shl;
                            MODE_SHR:  r_q <= w_shr;
                            MODE_LOAD: r_q <= d;
                            default:   r_q <= r_q;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    r_q <= w_auto;
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign q    = r_q;
    assign sout = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];
    assign busy = (r_state == ST_SHIFT);
    assign done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: vector table, frame sequences,
// width sweep and randomized run against a reference model.
module tb_univ_shift_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        sin = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  d = 8'h00;
    logic [7:0]  q;
    logic        sout, busy, done;

    logic        start2 = 1'b0;
    logic [1:0]  d2 = 2'b00;
    logic [1:0]  q2;
    logic        sout2, busy2, done2;

    logic        start32 = 1'b0;
    logic [31:0] d32 = 32'h0;
    logic [31:0] q32;
    logic        sout32, busy32, done32;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mq;
    int         mleft;
    logic       mdone;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .d(d), .sin(sin),
        .start(start), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    univ_shift_reg #(.WIDTH(2), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .d(d2), .sin(sin),
        .start(start2), .q(q2), .sout(sout2), .busy(busy2), .done(done2)
    );

    univ_shift_reg #(.WIDTH(32), .MSB_FIRST(1'b0)) dut32 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .d(d32), .sin(sin),
        .start(start32), .q(q32), .sout(sout32), .busy(busy32),
        .done(done32)
    );

    // Frame-level model: a frame is "mleft shifts still to go"
    task automatic model_step();
        if (!rst_n) begin
            mq = 8'h00;
            mleft = 0;
            mdone = 1'b0;
        end else begin
            mdone = 1'b0;
            if (mleft > 0) begin
                mq = 8'((mq * 2) + sin);
                mleft = mleft - 1;
                if (mleft == 0) mdone = 1'b1;
            end else if (start) begin
                mq = d;
                mleft = 8;
            end else begin
                case (mode)
                    2'b01: mq = 8'((mq * 2) + sin);
                    2'b10: mq = 8'((mq / 2) + (sin ? 128 : 0));
                    2'b11: mq = d;
                    default: mq = mq;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic run_frame8(input logic [7:0] dv);
        start = 1'b1;
        d = dv;
        mode = 2'($urandom);
        tick();
        chk("frame_load_q", q, dv);
        for (int i = 0; i < 8; i++) begin
            chk("frame_sout", sout, dv[7-i]);
            chk("frame_busy", busy, 1);
            chk("frame_done_low", done, 0);
            mode = 2'($urandom);
            start = 1'($urandom);
            d = 8'($urandom);
            sin = 1'($urandom);
            tick();
        end
        chk("frame_done", done, 1);
        chk("frame_idle", busy, 0);
        chk("frame_q_end", q, mq);
    endtask

    task automatic sweep(input int w);
        int nb, nd;
        logic [31:0] val, ev;
        logic bsy, so, dn;
        ev = (w == 2) ? 32'h2 : $urandom;
        mode = 2'b00;
        if (w == 2) begin
            start2 = 1'b1;
            d2 = ev[1:0];
        end else begin
            start32 = 1'b1;
            d32 = ev;
        end
        tick();
        start2 = 1'b0;
        start32 = 1'b0;
        nb = 0;
        nd = 0;
        val = '0;
        for (int c = 0; c < w + 4; c++) begin
            bsy = (w == 2) ? busy2 : busy32;
            so  = (w == 2) ? sout2 : sout32;
            dn  = (w == 2) ? done2 : done32;
            if (bsy) begin
                if (nb < 32) val[nb] = so;
                nb++;
            end
            if (dn) nd++;
            tick();
        end
        chk($sformatf("sweep%0d_busy_cycles", w), nb, w);
        chk($sformatf("sweep%0d_lsb_order", w), val, ev);
        chk($sformatf("sweep%0d_done_pulses", w), nd, 1);
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] md;
        logic       st;
        logic       si;
        logic [7:0] dv;
        logic [7:0] eq;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] c3;

    initial begin
        tbl[0] = '{1'b0, 2'b11, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 2'b11, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 2'b01, 1'b0, 1'b1, 8'h00, 8'h4B, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 8'h25, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 2'b00, 1'b0, 1'b1, 8'hFF, 8'h25, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 2'b11, 1'b1, 1'b0, 8'hC3, 8'hC3, 1'b1, 1'b0};
        mq = 8'h00;
        mleft = 0;
        mdone = 1'b0;

        for (int i = 0; i < 6; i++) begin
            rst_n = tbl[i].rst;
            mode  = tbl[i].md;
            start = tbl[i].st;
            sin   = tbl[i].si;
            d     = tbl[i].dv;
            tick();
            chk($sformatf("tbl%0d_q", i), q, tbl[i].eq);
            chk($sformatf("tbl%0d_sout", i), sout, tbl[i].eq[7]);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
        end

        // C3 serialized MSB first: 1,1,0,0,0,0,1,1
        c3 = 8'hC3;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("c3_sout", sout, c3[7-i]);
            chk("c3_busy", busy, 1);
            tick();
        end
        chk("c3_done", done, 1);
        chk("c3_done_busy", busy, 0);
        mode = 2'b00;
        tick();
        chk("c3_done_once", done, 0);

        run_frame8(8'h81);
        run_frame8(8'h7E);
        start = 1'b0;
        mode = 2'b00;
        tick();
        chk("b2b_done_once", done, 0);
        chk("b2b_idle", busy, 0);

        // Abort on the 4th shift edge
        start = 1'b1;
        d = 8'h5A;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("abort_pre_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("abort_q", q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_done", done, 0);
            chk("abort_stay_idle", busy, 0);
        end

        sweep(2);
        sweep(32);

        for (int i = 0; i < 400; i++) begin
            rst_n = (($urandom % 60) != 0);
            mode  = 2'($urandom);
            sin   = 1'($urandom);
            start = (($urandom % 6) == 0);
            d     = 8'($urandom);
            tick();
            chk("rnd_q", q, mq);
            chk("rnd_sout", sout, mq[7]);
            chk("rnd_busy", busy, (mleft > 0));
            chk("rnd_done", done, mdone);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
